au_csv_resolve_seq: RTL and testbench



---
 rtl/au_csv_resolve_seq_if.sv | 23 ++
 rtl/au_csv_resolve_seq.sv | 118 +++++++++++
 tb/tb_au_csv_resolve_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/au_csv_resolve_seq_if.sv
// Operand/result handshake bundle for the carry-save resolver.
// The master side offers s/c and consumes z; the slave side is the resolver.
interface au_csv_resolve_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH+1:0] z;

  modport master (
    output in_valid, s, c, out_ready,
    input  in_ready, out_valid, z
  );

  modport slave (
    input  in_valid, s, c, out_ready,
    output in_ready, out_valid, z
  );
endinterface

// File: rtl/au_csv_resolve_seq.sv
// Sequential carry-propagate resolver: z = s + 2*c, resolved SEG bits per
// cycle with a registered carry between segments. The interface instance must
// be built with the same WIDTH as this module.
module au_csv_resolve_seq #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  au_csv_resolve_seq_if.slave  bus,
  output logic                 busy
);
  localparam int W2   = WIDTH + 2;
  localparam int NSEG = (W2 + SEG - 1) / SEG;
  localparam int PW   = NSEG * SEG;          // W2 rounded up to whole segments
  localparam int KW   = $clog2(NSEG) + 1;    // holds 0..NSEG without wrapping

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [W2-1:0]   sa_reg, sa_next;
  logic [W2-1:0]   ca_reg, ca_next;
  logic [PW-1:0]   z_reg, z_next;
  logic            cy_reg, cy_next;
  logic [KW-1:0]   k_reg, k_next;
  logic            out_valid_reg, out_valid_next;

  logic [PW-1:0]   sa_pad, ca_pad;
  logic [SEG-1:0]  sa_seg, ca_seg;
  logic [SEG:0]    seg_sum;

  // Operands padded with zeros so every segment, including the last, is full width.
  assign sa_pad = PW'(sa_reg);
  assign ca_pad = PW'(ca_reg);

  // Select the segment addressed by k and add it with the carry from the previous segment.
  always_comb begin
    sa_seg = '0;
    ca_seg = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (k_reg == KW'(i)) begin
        sa_seg = sa_pad[i*SEG +: SEG];
        ca_seg = ca_pad[i*SEG +: SEG];
      end
    end
    seg_sum = {1'b0, sa_seg} + {1'b0, ca_seg} + {{SEG{1'b0}}, cy_reg};
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_next = state_reg;
    sa_next    = sa_reg;
    ca_next    = ca_reg;
    z_next     = z_reg;
    cy_next    = cy_reg;
    k_next     = k_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          sa_next    = W2'(bus.s);
          ca_next    = W2'({bus.c, 1'b0});
          cy_next    = 1'b0;
          k_next     = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NSEG; i++) begin
          if (k_reg == KW'(i)) begin
            z_next[i*SEG +: SEG] = seg_sum[SEG-1:0];
          end
        end
        cy_next = seg_sum[SEG];
        k_next  = k_reg + KW'(1);
        if (k_reg == KW'(NSEG - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    out_valid_next = (state_next == DONE);
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sa_reg        <= '0;
      ca_reg        <= '0;
      z_reg         <= '0;
      cy_reg        <= 1'b0;
      k_reg         <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sa_reg        <= sa_next;
      ca_reg        <= ca_next;
      z_reg         <= z_next;
      cy_reg        <= cy_next;
      k_reg         <= k_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.z         = z_reg[W2-1:0];
  assign busy          = (state_reg != IDLE);

  // s + 2*c always fits in W2 bits, so nothing may spill past the result.
  final_carry_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (state_reg == DONE) |-> (cy_reg == 1'b0 && (z_reg >> W2) == '0));
endmodule

// File: tb/tb_au_csv_resolve_seq.sv
// Directed and randomized bench for au_csv_resolve_seq across three parameter sets.
module tb_au_csv_resolve_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic busy_a, busy_b, busy_c;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  au_csv_resolve_seq_if #(.WIDTH(8)) ifa ();
  au_csv_resolve_seq_if #(.WIDTH(1)) ifb ();
  au_csv_resolve_seq_if #(.WIDTH(8)) ifc ();

  au_csv_resolve_seq #(.WIDTH(8), .SEG(4))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa), .busy(busy_a));
  au_csv_resolve_seq #(.WIDTH(1), .SEG(1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb), .busy(busy_b));
  au_csv_resolve_seq #(.WIDTH(8), .SEG(16)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc), .busy(busy_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the WIDTH=8/SEG=4 instance with out_ready held high.
  task automatic op_a(input logic [7:0] sv, input logic [7:0] cv, input string tag);
    int exp;
    exp = int'(sv) + 2 * int'(cv);
    check({tag, "_rdy0"}, ifa.in_ready, 1);
    ifa.s = sv; ifa.c = cv; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    ifa.s = 8'($urandom); ifa.c = 8'($urandom);
    check({tag, "_rdy_fall"}, ifa.in_ready, 0);
    check({tag, "_busy"}, busy_a, 1);
    tick(); check({tag, "_ov1"}, ifa.out_valid, 0);
    tick(); check({tag, "_ov2"}, ifa.out_valid, 0);
    tick(); check({tag, "_ov3"}, ifa.out_valid, 1);
    check({tag, "_z"}, 32'(ifa.z), exp);
    tick();
    check({tag, "_ov_drop"}, ifa.out_valid, 0);
    check({tag, "_idle"}, ifa.in_ready, 1);
    $display("op %s s=%0h c=%0h z_exp=%0h", tag, sv, cv, exp);
  endtask

  initial begin
    logic [7:0] a1, a2, a3, rs, rc;
    logic [7:0] hold_z;
    int exp, waited;
    logic r, hand;

    ifa.in_valid = 0; ifa.s = 0; ifa.c = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.s = 0; ifb.c = 0; ifb.out_ready = 0;
    ifc.in_valid = 0; ifc.s = 0; ifc.c = 0; ifc.out_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", ifa.in_ready, 1);
    check("rst_out_valid", ifa.out_valid, 0);
    check("rst_z", 32'(ifa.z), 0);
    check("rst_busy", busy_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    op_a(8'hFF, 8'hFF, "ff_ff");
    check("ff_ff_const", 32'(765), int'(8'hFF) + 2 * int'(8'hFF));
    op_a(8'h55, 8'hAA, "55_aa");
    op_a(8'h00, 8'h00, "zero");
    op_a(8'h01, 8'h00, "one");

    // Backpressure: result held while downstream stalls and new inputs arrive.
    ifa.out_ready = 1'b0;
    ifa.s = 8'h3C; ifa.c = 8'h5A; ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    tick(); tick(); tick();
    check("bp_ov", ifa.out_valid, 1);
    check("bp_z", 32'(ifa.z), 32'h0F0);
    for (int i = 0; i < 6; i++) begin
      ifa.in_valid = 1'(i);
      ifa.s = 8'($urandom); ifa.c = 8'($urandom);
      tick();
      check("bp_hold_ov", ifa.out_valid, 1);
      check("bp_hold_z", 32'(ifa.z), 32'h0F0);
      check("bp_hold_rdy", ifa.in_ready, 0);
    end
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
    tick();
    check("bp_hand_ov", ifa.out_valid, 0);
    check("bp_hand_rdy", ifa.in_ready, 1);
    tick();
    check("bp_no_capture", busy_a, 0);
    $display("op backpressure z_exp=0f0");

    // Reset while the resolver is part-way through RUN.
    ifa.s = 8'hFF; ifa.c = 8'hFF; ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ov", ifa.out_valid, 0);
    check("mid_rst_z", 32'(ifa.z), 0);
    check("mid_rst_rdy", ifa.in_ready, 1);
    check("mid_rst_busy", busy_a, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_ov", ifa.out_valid, 0);
      check("post_rst_busy", busy_a, 0);
    end
    $display("op mid-run reset");
    op_a(8'h10, 8'h08, "after_rst");

    // WIDTH=1, SEG=1: three RUN cycles per result.
    for (int v = 0; v < 4; v++) begin
      ifb.s = 1'(v); ifb.c = 1'(v >> 1); ifb.in_valid = 1'b1; ifb.out_ready = 1'b1;
      tick();
      ifb.in_valid = 1'b0;
      check("b_busy", busy_b, 1);
      tick(); check("b_ov1", ifb.out_valid, 0);
      tick(); check("b_ov2", ifb.out_valid, 0);
      tick(); check("b_ov3", ifb.out_valid, 1);
      check("b_z", 32'(ifb.z), (v & 1) + 2 * (v >> 1));
      tick(); check("b_idle", ifb.in_ready, 1);
      $display("op w1 s=%0d c=%0d z_exp=%0d", v & 1, v >> 1, (v & 1) + 2 * (v >> 1));
    end

    // WIDTH=8, SEG=16: single RUN cycle.
    for (int i = 0; i < 4; i++) begin
      rs = (i == 0) ? 8'hFF : 8'($urandom);
      rc = (i == 0) ? 8'hFF : 8'($urandom);
      exp = int'(rs) + 2 * int'(rc);
      ifc.s = rs; ifc.c = rc; ifc.in_valid = 1'b1; ifc.out_ready = 1'b1;
      tick();
      ifc.in_valid = 1'b0;
      check("c_rdy_fall", ifc.in_ready, 0);
      tick();
      check("c_ov", ifc.out_valid, 1);
      check("c_z", 32'(ifc.z), exp);
      tick();
      check("c_idle", ifc.in_ready, 1);
      $display("op seg16 s=%0h c=%0h z_exp=%0h", rs, rc, exp);
    end

    // Random chain: three operands compressed to carry-save form, then resolved.
    for (int n = 0; n < 1000; n++) begin
      a1 = 8'($urandom); a2 = 8'($urandom); a3 = 8'($urandom);
      exp = int'(a1) + int'(a2) + int'(a3);
      ifa.s = a1 ^ a2 ^ a3;
      ifa.c = (a1 & a2) | (a1 & a3) | (a2 & a3);
      ifa.in_valid = 1'b1;
      ifa.out_ready = 1'($urandom_range(0, 1));
      tick();
      ifa.in_valid = 1'b0;
      waited = 0;
      while (!ifa.out_valid && waited < 20) begin
        ifa.out_ready = 1'($urandom_range(0, 1));
        tick();
        waited++;
      end
      check("rnd_latency", waited, 3);
      check("rnd_z", 32'(ifa.z), exp);
      hold_z = ifa.z[7:0];
      hand = 1'b0;
      waited = 0;
      while (!hand && waited < 20) begin
        r = (waited == 19) ? 1'b1 : 1'($urandom_range(0, 1));
        ifa.out_ready = r;
        tick();
        if (r) hand = 1'b1;
        else check("rnd_stall_z", 32'(ifa.z[7:0]), 32'(hold_z));
        waited++;
      end
      check("rnd_handoff", ifa.in_ready, 1);
      $display("op rnd %0d a=%0h,%0h,%0h z_exp=%0h", n, a1, a2, a3, exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
